// File: rtl/rgb_to_ycbcr_pkg.sv
// Shared constants and types for the RGB -> level-shifted YCbCr converter.
// Coefficients are 8-bit-fraction fixed point (scale 256).
package rgb_to_ycbcr_pkg;

  localparam int DATA_W  = 8;
  localparam int COEF_W  = 9;
  localparam int STAGES  = 2;
  localparam int ACC_W   = 19;
  localparam int FIELD_W = 10;

  localparam int signed Y_R  = 77;
  localparam int signed Y_G  = 150;
  localparam int signed Y_B  = 29;
  localparam int signed CB_R = -43;
  localparam int signed CB_G = -85;
  localparam int signed CB_B = 128;
  localparam int signed CR_R = 128;
  localparam int signed CR_G = -107;
  localparam int signed CR_B = -21;

  localparam int signed ROUND_C   = 128;
  localparam int        SHIFT     = 8;
  localparam int signed LVL_OFS   = 128;
  localparam int signed CLAMP_MIN = -128;
  localparam int signed CLAMP_MAX = 127;

  typedef struct packed {
    logic [FIELD_W-1:0] y;
    logic [FIELD_W-1:0] cb;
    logic [FIELD_W-1:0] cr;
  } ycc_t;

endpackage

// File: rtl/ycc_channel.sv
// One output channel: three weighted pixel products, then sum, round,
// floor-shift, optional -128 level shift and clamp to a signed 8-bit range.
module ycc_channel
  import rgb_to_ycbcr_pkg::*;
#(
  parameter int C_R       = 0,
  parameter int C_G       = 0,
  parameter int C_B       = 0,
  parameter bit LVL_SHIFT = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      vld_p0_i,
  input  logic                      vld_p1_i,
  input  logic [DATA_W-1:0]         r_i,
  input  logic [DATA_W-1:0]         g_i,
  input  logic [DATA_W-1:0]         b_i,
  output logic signed [FIELD_W-1:0] ch_o
);

  function automatic logic signed [ACC_W-1:0] mul(input int coef, input logic [DATA_W-1:0] px);
    logic signed [COEF_W-1:0] c;
    logic signed [ACC_W-1:0]  c_x;
    logic signed [ACC_W-1:0]  p_x;
    c   = COEF_W'(coef);
    c_x = ACC_W'(c);
    p_x = ACC_W'({1'b0, px});
    return c_x * p_x;
  endfunction

  // Arithmetic shift gives floor division, so negative sums round toward -inf.
  function automatic logic signed [ACC_W-1:0] rnd_shift(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] t;
    t = v + ACC_W'(ROUND_C);
    return t >>> SHIFT;
  endfunction

  function automatic logic signed [FIELD_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = ACC_W'(CLAMP_MAX);
    lo = ACC_W'(CLAMP_MIN);
    if (v > hi) return FIELD_W'(hi);
    if (v < lo) return FIELD_W'(lo);
    return FIELD_W'(v);
  endfunction

  logic signed [ACC_W-1:0]   pr_p1_d, pg_p1_d, pb_p1_d;
  logic signed [ACC_W-1:0]   pr_p1_q, pg_p1_q, pb_p1_q;
  logic signed [ACC_W-1:0]   acc_p1;
  logic signed [FIELD_W-1:0] ch_p2_d;
  logic signed [FIELD_W-1:0] ch_p2_q;

  // Stage 1: nine products across the three channels, three per channel.
  always_comb begin
    pr_p1_d = mul(C_R, r_i);
    pg_p1_d = mul(C_G, g_i);
    pb_p1_d = mul(C_B, b_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pr_p1_q <= '0;
      pg_p1_q <= '0;
      pb_p1_q <= '0;
    end else if (vld_p0_i) begin
      pr_p1_q <= pr_p1_d;
      pg_p1_q <= pg_p1_d;
      pb_p1_q <= pb_p1_d;
    end
  end

  // Stage 2: sum, round, shift, level shift and clamp.
  always_comb begin
    acc_p1 = rnd_shift(pr_p1_q + pg_p1_q + pb_p1_q);
    if (LVL_SHIFT) acc_p1 = acc_p1 - ACC_W'(LVL_OFS);
    ch_p2_d = sat(acc_p1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         ch_p2_q <= '0;
    else if (vld_p1_i) ch_p2_q <= ch_p2_d;
  end

  assign ch_o = ch_p2_q;

endmodule

// File: rtl/rgb_to_ycbcr.sv
// RGB to level-shifted YCbCr (JPEG DCT input), two-cycle fixed latency.
// Three channel slices share one valid pipeline owned here.
module rgb_to_ycbcr
  import rgb_to_ycbcr_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      r,
  input  logic [DATA_W-1:0]      g,
  input  logic [DATA_W-1:0]      b,
  output logic [3*FIELD_W-1:0]   out,
  output logic                   out_valid
);

  logic vld_p1_q, vld_p2_q;
  logic signed [FIELD_W-1:0] y_p2, cb_p2, cr_p2;
  ycc_t res_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= in_valid;
      vld_p2_q <= vld_p1_q;
    end
  end

  ycc_channel #(.C_R(Y_R), .C_G(Y_G), .C_B(Y_B), .LVL_SHIFT(1'b1)) u_y (
    .clk_i(clk), .rst_i(reset), .vld_p0_i(in_valid), .vld_p1_i(vld_p1_q),
    .r_i(r), .g_i(g), .b_i(b), .ch_o(y_p2)
  );

  ycc_channel #(.C_R(CB_R), .C_G(CB_G), .C_B(CB_B), .LVL_SHIFT(1'b0)) u_cb (
    .clk_i(clk), .rst_i(reset), .vld_p0_i(in_valid), .vld_p1_i(vld_p1_q),
    .r_i(r), .g_i(g), .b_i(b), .ch_o(cb_p2)
  );

  ycc_channel #(.C_R(CR_R), .C_G(CR_G), .C_B(CR_B), .LVL_SHIFT(1'b0)) u_cr (
    .clk_i(clk), .rst_i(reset), .vld_p0_i(in_valid), .vld_p1_i(vld_p1_q),
    .r_i(r), .g_i(g), .b_i(b), .ch_o(cr_p2)
  );

  always_comb begin
    res_p2.y  = y_p2;
    res_p2.cb = cb_p2;
    res_p2.cr = cr_p2;
  end

  assign out       = res_p2;
  assign out_valid = vld_p2_q;

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Scoreboard bench for rgb_to_ycbcr: a driver pushes expected results with
// their due cycle, a monitor checks every cycle against the queue.
module tb_rgb_to_ycbcr;

  typedef struct {
    logic [29:0] exp;
    int          due;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
  logic [29:0] out;
  logic        out_valid;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          in_reset = 1'b1;
  logic [29:0] last_out = '0;
  sb_item_t    sb[$];

  rgb_to_ycbcr dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .r(r), .g(g), .b(b), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [9:0] clamp10(input int v);
    int c;
    c = (v > 127) ? 127 : (v < -128) ? -128 : v;
    return 10'(c);
  endfunction

  // Reference: plain integer arithmetic straight from the conversion formulas.
  function automatic logic [29:0] model(input int rr, input int gg, input int bb);
    int y, cb, cr;
    y  = ((77 * rr + 150 * gg + 29 * bb + 128) >>> 8) - 128;
    cb = (-43 * rr - 85 * gg + 128 * bb + 128) >>> 8;
    cr = (128 * rr - 107 * gg - 21 * bb + 128) >>> 8;
    return {clamp10(y), clamp10(cb), clamp10(cr)};
  endfunction

  function automatic logic [29:0] pack3(input int y, input int cb, input int cr);
    return {10'(y), 10'(cb), 10'(cr)};
  endfunction

  task automatic check(input string name, input logic [29:0] act, input logic [29:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
    end
  endtask

  // Drive in the current cycle (caller is already at a negedge).
  task automatic issue_now(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                           input logic [29:0] exp);
    sb_item_t it;
    in_valid = 1'b1;
    r = rr; g = gg; b = bb;
    it.exp = exp;
    it.due = cyc + 2;
    sb.push_back(it);
  endtask

  task automatic send(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                      input logic [29:0] exp);
    @(negedge clk);
    issue_now(rr, gg, bb, exp);
  endtask

  task automatic send_rand();
    logic [7:0] rr, gg, bb;
    rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
    send(rr, gg, bb, model(rr, gg, bb));
  endtask

  // Idle cycles still toggle the pixel inputs so a missing load enable shows up.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    end
  endtask

  task automatic do_reset(input bit send_after);
    logic [7:0] rr, gg, bb;
    @(negedge clk);
    reset = 1'b1;
    in_reset = 1'b1;
    in_valid = 1'b1;
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    sb.delete();
    @(negedge clk);
    check("rst_out", out, 30'd0);
    check("rst_out_valid", {29'd0, out_valid}, 30'd0);
    @(negedge clk);
    reset = 1'b0;
    last_out = '0;
    in_reset = 1'b0;
    if (send_after) begin
      rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
      issue_now(rr, gg, bb, model(rr, gg, bb));
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Monitor: out_valid must appear exactly on an item's due cycle; otherwise out holds.
  always @(posedge clk) begin
    #1;
    if (!in_reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {29'd0, out_valid}, 30'd0);
        end else begin
          check("valid_timing", 30'(cyc), 30'(sb[0].due));
          check("result", out, sb[0].exp);
          void'(sb.pop_front());
        end
        last_out = out;
      end else begin
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          check("missing_valid", {29'd0, out_valid}, 30'd1);
          void'(sb.pop_front());
        end
        check("hold", out, last_out);
      end
    end
  end

  initial begin
    do_reset(1'b0);
    idle(2);

    // Corner colours with hand-derived expectations.
    send(8'd0,   8'd0,   8'd0,   pack3(-128,   0,    0));
    send(8'd255, 8'd255, 8'd255, pack3( 127,   0,    0));
    send(8'd255, 8'd0,   8'd0,   pack3( -51, -43,  127));
    send(8'd0,   8'd255, 8'd0,   pack3(  21, -85, -107));
    send(8'd0,   8'd0,   8'd255, pack3( -99, 127,  -21));
    idle(3);

    for (int i = 0; i < 5; i++) send_rand();
    idle(2);
    for (int i = 0; i < 5; i++) send_rand();
    idle(3);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) != 0) send_rand();
      else idle(1);
    end
    idle(3);

    // Reset with samples in flight; then a sample on the first free cycle.
    send_rand();
    send_rand();
    do_reset(1'b1);
    idle(1);
    send_rand();
    idle(6);

    check("queue_drained", 30'(sb.size()), 30'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
